// File: rtl/pump_safe_sequencer.sv
// Pump/pressure startup interlock with reverse-order shutdown.
// Every wait is supervised by a timeout, and any sequence violation latches FAULT.
module pump_safe_sequencer #(
  parameter int SPINUP_TIMEOUT = 1000,
  parameter int RUNDOWN_CYCLES = 200,
  parameter int DECAY_TIMEOUT  = 1000
) (
  input  logic       System_Clock,
  input  logic       System_Reset,
  input  logic       Start_Request,
  input  logic       Stop_Request,
  input  logic       Fault_Clear,
  input  logic       Pressure_OK_Signal,
  output logic       Pump_ON_Signal,
  output logic       Master_Start,
  output logic       Fault,
  output logic [2:0] State,
  output logic       Sequence_Done
);

  localparam int MAX_A = (SPINUP_TIMEOUT > RUNDOWN_CYCLES) ? SPINUP_TIMEOUT : RUNDOWN_CYCLES;
  localparam int MAX_P = (MAX_A > DECAY_TIMEOUT) ? MAX_A : DECAY_TIMEOUT;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] SPINUP_LAST  = CW'(SPINUP_TIMEOUT - 1);
  localparam logic [CW-1:0] RUNDOWN_LAST = CW'(RUNDOWN_CYCLES - 1);
  localparam logic [CW-1:0] DECAY_LAST   = CW'(DECAY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPINUP  = 3'd1,
    RUN     = 3'd2,
    RUNDOWN = 3'd3,
    DECAY   = 3'd4,
    FAULT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, p_sync_q;
  logic          pump_q, pump_d;
  logic          master_q, master_d;
  logic          fault_q, fault_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start_Request && p_sync_q)          state_d = FAULT;
        else if (Start_Request && !Stop_Request) state_d = SPINUP;
      end
      SPINUP: begin
        if (Stop_Request)              state_d = DECAY;
        else if (p_sync_q)             state_d = RUN;
        else if (cnt_q == SPINUP_LAST) state_d = FAULT;
      end
      RUN: begin
        if (!p_sync_q)         state_d = FAULT;
        else if (Stop_Request) state_d = RUNDOWN;
      end
      RUNDOWN: begin
        if (cnt_q == RUNDOWN_LAST) state_d = DECAY;
      end
      DECAY: begin
        if (!p_sync_q)                state_d = IDLE;
        else if (cnt_q == DECAY_LAST) state_d = FAULT;
      end
      FAULT: begin
        if (Fault_Clear && !p_sync_q) state_d = IDLE;
      end
      default: state_d = FAULT;
    endcase

    // Counter restarts on any state change; it free-runs (and may wrap) where unused.
    cnt_d    = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    pump_d   = (state_d == SPINUP) || (state_d == RUN) || (state_d == RUNDOWN);
    master_d = (state_d == RUN);
    fault_d  = (state_d == FAULT);
    done_d   = (state_q == DECAY) && (state_d == IDLE);
  end

  always_ff @(posedge System_Clock or posedge System_Reset) begin
    if (System_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sync1_q  <= 1'b0;
      p_sync_q <= 1'b0;
      pump_q   <= 1'b0;
      master_q <= 1'b0;
      fault_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync1_q  <= Pressure_OK_Signal;
      p_sync_q <= sync1_q;
      pump_q   <= pump_d;
      master_q <= master_d;
      fault_q  <= fault_d;
      done_q   <= done_d;
    end
  end

  assign State          = state_q;
  assign Pump_ON_Signal = pump_q;
  assign Master_Start   = master_q;
  assign Fault          = fault_q;
  assign Sequence_Done  = done_q;

endmodule

// File: tb/tb_pump_safe_sequencer.sv
// Bench for pump_safe_sequencer: directed scenarios plus a randomized run
// checked against a time-in-state reference model.
module tb_pump_safe_sequencer;

  localparam int SPIN_T = 8;
  localparam int RD_C   = 4;
  localparam int DEC_T  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, clear, pressure;
  logic       pump, master, fault, done;
  logic [2:0] st;

  int tests = 0;
  int fails = 0;

  pump_safe_sequencer #(
    .SPINUP_TIMEOUT(SPIN_T),
    .RUNDOWN_CYCLES(RD_C),
    .DECAY_TIMEOUT (DEC_T)
  ) dut (
    .System_Clock      (clk),
    .System_Reset      (rst),
    .Start_Request     (start),
    .Stop_Request      (stop),
    .Fault_Clear       (clear),
    .Pressure_OK_Signal(pressure),
    .Pump_ON_Signal    (pump),
    .Master_Start      (master),
    .Fault             (fault),
    .State             (st),
    .Sequence_Done     (done)
  );

  always #5 clk = ~clk;

  logic m_prev = 1'b0;
  logic p_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(master && !pump)) else $error("Master_Start without Pump_ON");
      assert (!(master && !m_prev && !p_prev)) else $error("Master_Start rose with Pump_ON");
    end
    m_prev = master;
    p_prev = pump;
  end

  function automatic logic [6:0] obs();
    return {st, pump, master, fault, done};
  endfunction

  // Expected outputs from a state number: pump in 1..3, master in 2, fault in 5.
  function automatic logic [6:0] expv(input int s, input bit d);
    logic [2:0] s3;
    s3 = 3'(s);
    return {s3, (s >= 1 && s <= 3), (s == 2), (s == 5), d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic p);
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; pressure = p;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic go_run();
    do_reset(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    pressure = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0; pressure = 1'b0;
    step();
    tests++;
    if (obs() !== 7'd0) begin
      fails++; $display("FAIL reset_outputs: got %b want %b", obs(), 7'd0);
    end
    step();
    rst = 1'b0; start = 1'b0;
    step();
    tests++;
    if (obs() !== expv(0, 0)) begin
      fails++; $display("FAIL reset_idle: got %b want %b", obs(), expv(0, 0));
    end
  endtask

  task automatic test_nominal();
    int es;
    do_reset(1'b0);
    start = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      start = 1'b0;
      es = (e < 6) ? 1 : 2;
      tests++;
      if (obs() !== expv(es, 0)) begin
        fails++; $display("FAIL nominal_e%0d: got %b want %b", e, obs(), expv(es, 0));
      end
      if (e == 3) pressure = 1'b1;
    end
  endtask

  task automatic test_shutdown();
    int es;
    bit ed;
    stop = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      stop = 1'b0;
      es = (e <= 4) ? 3 : (e <= 7) ? 4 : 0;
      ed = (e == 8);
      tests++;
      if (obs() !== expv(es, ed)) begin
        fails++; $display("FAIL shutdown_e%0d: got %b want %b", e, obs(), expv(es, ed));
      end
      if (e == 5) pressure = 1'b0;
    end
  endtask

  task automatic test_spinup_timeout();
    int es;
    do_reset(1'b0);
    start = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      start = 1'b0;
      es = (e <= 8) ? 1 : 5;
      tests++;
      if (obs() !== expv(es, 0)) begin
        fails++; $display("FAIL spin_timeout_e%0d: got %b want %b", e, obs(), expv(es, 0));
      end
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (obs() !== expv(0, 0)) begin
      fails++; $display("FAIL spin_clear: got %b want %b", obs(), expv(0, 0));
    end
  endtask

  task automatic test_emergency();
    go_run();
    pressure = 1'b0;
    step();
    step();
    tests++;
    if (obs() !== expv(2, 0)) begin
      fails++; $display("FAIL emerg_still_run: got %b want %b", obs(), expv(2, 0));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests++;
    if (obs() !== expv(5, 0)) begin
      fails++; $display("FAIL emerg_fault: got %b want %b", obs(), expv(5, 0));
    end
  endtask

  task automatic test_stale_sensor();
    do_reset(1'b1);
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (obs() !== expv(5, 0)) begin
      fails++; $display("FAIL stale_start: got %b want %b", obs(), expv(5, 0));
    end
    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
    tests++;
    if (obs() !== expv(5, 0)) begin
      fails++; $display("FAIL clear_with_pressure: got %b want %b", obs(), expv(5, 0));
    end
    pressure = 1'b0;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (obs() !== expv(0, 0)) begin
      fails++; $display("FAIL clear_no_pressure: got %b want %b", obs(), expv(0, 0));
    end
  endtask

  task automatic test_decay_stuck();
    int es;
    go_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (4) step();
    tests++;
    if (obs() !== expv(4, 0)) begin
      fails++; $display("FAIL decay_entry: got %b want %b", obs(), expv(4, 0));
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      es = (k < 8) ? 4 : 5;
      tests++;
      if (obs() !== expv(es, 0)) begin
        fails++; $display("FAIL decay_stuck_k%0d: got %b want %b", k, obs(), expv(es, 0));
      end
    end
  endtask

  task automatic test_reset_mid_rundown();
    go_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    step();
    tests++;
    if (obs() !== expv(3, 0)) begin
      fails++; $display("FAIL rundown_before_reset: got %b want %b", obs(), expv(3, 0));
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (obs() !== 7'd0) begin
      fails++; $display("FAIL async_reset_outputs: got %b want %b", obs(), 7'd0);
    end
    pressure = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      tests++;
      if (obs() !== expv(0, 0)) begin
        fails++; $display("FAIL post_reset_idle_k%0d: got %b want %b", k, obs(), expv(0, 0));
      end
    end
  endtask

  // Reference model: state number, cycles spent in it, and the two-stage pressure view.
  int m_st, m_dwell;
  bit m_s1, m_s2, m_done;

  task automatic model_edge();
    int nx;
    bit ps;
    ps = m_s2;
    nx = m_st;
    case (m_st)
      0: if (start && ps) nx = 5; else if (start && !stop) nx = 1;
      1: if (stop) nx = 4; else if (ps) nx = 2; else if (m_dwell == SPIN_T - 1) nx = 5;
      2: if (!ps) nx = 5; else if (stop) nx = 3;
      3: if (m_dwell == RD_C - 1) nx = 4;
      4: if (!ps) nx = 0; else if (m_dwell == DEC_T - 1) nx = 5;
      default: if (clear && !ps) nx = 0;
    endcase
    m_done  = (m_st == 4) && (nx == 0);
    m_dwell = (nx == m_st) ? m_dwell + 1 : 0;
    m_s2    = m_s1;
    m_s1    = pressure;
    m_st    = nx;
  endtask

  task automatic test_random();
    do_reset(1'b0);
    m_st = 0; m_dwell = 0; m_s1 = 1'b0; m_s2 = 1'b0; m_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 11) == 0) pressure = ~pressure;
      model_edge();
      step();
      tests++;
      if (obs() !== expv(m_st, m_done)) begin
        fails++; $display("FAIL random_c%0d: got %b want %b", c, obs(), expv(m_st, m_done));
      end
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; pressure = 1'b0;
    test_reset();
    test_nominal();
    test_shutdown();
    test_spinup_timeout();
    test_emergency();
    test_stale_sensor();
    test_decay_stuck();
    test_reset_mid_rundown();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
